// File: rtl/posit_dot_sched_if.sv
// Command / operand / result channels of the posit8 dot-product sequencer.
// slave is the sequencer side, master is the host/DMA side.
interface posit_dot_sched_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       cmd_acc_init;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_nar;
  logic             busy;
  logic [LEN_W-1:0] ops_done;

  modport slave (
    input  cmd_valid, cmd_len, cmd_acc_init, op_valid, op_a, op_b, res_ready,
    output cmd_ready, op_ready, res_valid, res_data, res_nar, busy, ops_done
  );

  modport master (
    output cmd_valid, cmd_len, cmd_acc_init, op_valid, op_a, op_b, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data, res_nar, busy, ops_done
  );
endinterface

// File: rtl/posit_dot_sched.sv
// posit8 (es=0) fused multiply-add plus the command-framed sequencer that
// streams operand pairs through it and returns one rounded result per command.
module posit_mac_8bit (
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [7:0] in_c,
  output logic [7:0] out
);
  // Every posit8 es=0 value is an exact multiple of 2^-6; decode to value*64.
  function automatic logic signed [13:0] decode(input logic [7:0] p);
    logic [6:0]  body;
    logic [13:0] t;
    logic [6:0]  frac7;
    logic [19:0] wide;
    logic [12:0] fix;
    logic        seen;
    int          run;
    int          e;
    body = p[7] ? 7'(~p + 8'd1) : p[6:0];
    run  = 0;
    seen = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!seen && body[i] == body[6]) run++;
      else seen = 1'b1;
    end
    t     = {body, 7'b0} << (run + 1);
    frac7 = 7'(t >> 7);
    e     = body[6] ? run + 5 : 6 - run;
    wide  = {12'b0, 1'b1, frac7} << e;
    fix   = 13'(wide >> 7);
    if (p == 8'h00)  decode = 14'sd0;
    else if (p[7])   decode = -$signed({1'b0, fix});
    else             decode = $signed({1'b0, fix});
  endfunction

  // Exact sum (12 fraction bits) rounded once, nearest-even on the bit pattern,
  // saturating at maxpos/minpos so nonzero never becomes zero or NaR.
  function automatic logic [7:0] encode(input logic signed [28:0] s);
    logic [28:0] mag;
    logic [27:0] frac;
    logic [6:0]  rtop;
    logic [6:0]  body;
    logic [34:0] lng;
    int          p;
    int          k;
    int          rl;
    mag = s[28] ? 29'(-s) : 29'(s);
    p   = 0;
    for (int i = 0; i < 29; i++) if (mag[i]) p = i;
    k    = p - 12;
    frac = 28'(mag << (28 - p));
    if (k >= 0) begin
      rtop = 7'h7F << (6 - k);
      rl   = k + 2;
    end else begin
      rtop = 7'h40 >> (-k);
      rl   = 1 - k;
    end
    lng  = {rtop, 28'b0} | (35'(frac) << (7 - rl));
    body = lng[34:28];
    if (lng[27] && ((|lng[26:0]) || body[0])) body = body + 7'd1;
    if (k >= 6)       body = 7'h7F;
    else if (k < -6)  body = 7'h01;
    if (mag == 29'd0) encode = 8'h00;
    else if (s[28])   encode = ~{1'b0, body} + 8'd1;
    else              encode = {1'b0, body};
  endfunction

  logic signed [13:0] fa, fb, fc;
  logic signed [27:0] prod;
  logic signed [28:0] sum;

  always_comb begin
    fa   = decode(in_a);
    fb   = decode(in_b);
    fc   = decode(in_c);
    prod = 28'(fa) * 28'(fb);
    sum  = 29'(prod) + (29'(fc) <<< 6);
    if (in_a == 8'h80 || in_b == 8'h80 || in_c == 8'h80) out = 8'h80;
    else                                                out = encode(sum);
  end
endmodule

// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | consuming operand pairs into acc, op_ready high
// DONE  | result held on res_* until res_ready
module posit_dot_sched #(
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  posit_dot_sched_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [7:0]       acc, acc_nx, res_data, res_data_nx, mac_out, acc_step;
  logic [LEN_W-1:0] remaining, remaining_nx, ops_done, ops_done_nx;
  logic             res_valid, res_valid_nx, res_nar, res_nar_nx, nar, nar_nx;
  logic             mac_nar, init_nar;

  posit_mac_8bit u_mac (
    .in_a (bus.op_a),
    .in_b (bus.op_b),
    .in_c (acc),
    .out  (mac_out)
  );

  assign mac_nar  = (mac_out == 8'h80);
  assign init_nar = (bus.cmd_acc_init == 8'h80);
  // Sticky NaR wins even when a zero operand would bypass to acc.
  assign acc_step = (nar || mac_nar) ? 8'h80 : mac_out;

  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    remaining_nx = remaining;
    ops_done_nx  = ops_done;
    res_data_nx  = res_data;
    res_valid_nx = res_valid;
    res_nar_nx   = res_nar;
    nar_nx       = nar;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        acc_nx      = bus.cmd_acc_init;
        ops_done_nx = '0;
        nar_nx      = init_nar;
        if (bus.cmd_len == '0) begin
          res_data_nx  = bus.cmd_acc_init;
          res_nar_nx   = init_nar;
          res_valid_nx = 1'b1;
          state_nx     = DONE;
        end else begin
          remaining_nx = bus.cmd_len;
          state_nx     = RUN;
        end
      end
      RUN: if (bus.op_valid) begin
        acc_nx       = acc_step;
        nar_nx       = nar | mac_nar;
        ops_done_nx  = ops_done + LEN_W'(1);
        remaining_nx = remaining - LEN_W'(1);
        if (remaining == LEN_W'(1)) begin
          res_data_nx  = acc_step;
          res_nar_nx   = nar | mac_nar;
          res_valid_nx = 1'b1;
          state_nx     = DONE;
        end
      end
      DONE: if (bus.res_ready) begin
        res_valid_nx = 1'b0;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 8'h00;
      remaining <= '0;
      ops_done  <= '0;
      res_data  <= 8'h00;
      res_valid <= 1'b0;
      res_nar   <= 1'b0;
      nar       <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      remaining <= remaining_nx;
      ops_done  <= ops_done_nx;
      res_data  <= res_data_nx;
      res_valid <= res_valid_nx;
      res_nar   <= res_nar_nx;
      nar       <= nar_nx;
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.op_ready  = (state == RUN);
  assign bus.busy      = (state != IDLE);
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_nar   = res_nar;
  assign bus.ops_done  = ops_done;
endmodule

// File: tb/tb_posit_dot_sched.sv
// Directed bench for posit_dot_sched: a table of hand-computed dot products
// plus hand-written flow-control, idle-operand and mid-command reset sequences.
module tb_posit_dot_sched;
  logic clk = 1'b0;
  logic rst;

  posit_dot_sched_if #(.LEN_W(8)) bus ();
  posit_dot_sched #(.LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]      len;
    logic [7:0]      init;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [7:0]      exp_d;
    logic            exp_n;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [3:0][7:0] pk(input logic [7:0] x0, x1, x2, x3);
    pk = {x3, x2, x1, x0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input string nm, input logic [7:0] len, input logic [7:0] init,
                         input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                         input int gap, input int hold,
                         input logic [7:0] exp_d, input logic exp_n);
    check({nm, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.res_ready    = 1'b0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_len      = len;
    bus.cmd_acc_init = init;
    tick;
    bus.cmd_valid = 1'b0;
    if (len == 8'd0) begin
      check({nm, "_op_ready_len0"}, 32'(bus.op_ready), 32'd0);
    end else begin
      check({nm, "_op_ready"}, 32'(bus.op_ready), 32'd1);
      for (int i = 0; i < int'(len); i++) begin
        for (int g = 0; g < gap; g++) begin
          bus.op_valid = 1'b0;
          tick;
          check({nm, "_gap_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
          check({nm, "_gap_ops_done"}, 32'(bus.ops_done), 32'(i));
        end
        bus.op_valid = 1'b1;
        bus.op_a     = a[i];
        bus.op_b     = b[i];
        check({nm, "_ops_done_pre"}, 32'(bus.ops_done), 32'(i));
        check({nm, "_res_valid_early"}, 32'(bus.res_valid), 32'd0);
        tick;
      end
      bus.op_valid = 1'b0;
    end
    check({nm, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    check({nm, "_res_data"}, 32'(bus.res_data), 32'(exp_d));
    check({nm, "_res_nar"}, 32'(bus.res_nar), 32'(exp_n));
    check({nm, "_ops_done"}, 32'(bus.ops_done), 32'(len));
    check({nm, "_busy"}, 32'(bus.busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      tick;
      check({nm, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
      check({nm, "_hold_data"}, 32'(bus.res_data), 32'(exp_d));
      check({nm, "_hold_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    tick;
    bus.res_ready = 1'b0;
    check({nm, "_post_valid"}, 32'(bus.res_valid), 32'd0);
    check({nm, "_post_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({nm, "_post_busy"}, 32'(bus.busy), 32'd0);
    check({nm, "_post_data_kept"}, 32'(bus.res_data), 32'(exp_d));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'd3, 8'h00, pk(8'h40, 8'h40, 8'h20, 8'h00), pk(8'h40, 8'h60, 8'h60, 8'h00), 8'h70, 1'b0};
    vecs[1]  = '{8'd0, 8'h68, pk(8'h00, 8'h00, 8'h00, 8'h00), pk(8'h00, 8'h00, 8'h00, 8'h00), 8'h68, 1'b0};
    vecs[2]  = '{8'd3, 8'h40, pk(8'h80, 8'h00, 8'h40, 8'h00), pk(8'h40, 8'h40, 8'h40, 8'h00), 8'h80, 1'b1};
    vecs[3]  = '{8'd1, 8'h00, pk(8'h60, 8'h00, 8'h00, 8'h00), pk(8'h60, 8'h00, 8'h00, 8'h00), 8'h70, 1'b0};
    vecs[4]  = '{8'd2, 8'h00, pk(8'h40, 8'hC0, 8'h00, 8'h00), pk(8'h40, 8'h40, 8'h00, 8'h00), 8'h00, 1'b0};
    vecs[5]  = '{8'd1, 8'h40, pk(8'h60, 8'h00, 8'h00, 8'h00), pk(8'h60, 8'h00, 8'h00, 8'h00), 8'h72, 1'b0};
    vecs[6]  = '{8'd1, 8'h00, pk(8'h7F, 8'h00, 8'h00, 8'h00), pk(8'h7F, 8'h00, 8'h00, 8'h00), 8'h7F, 1'b0};
    vecs[7]  = '{8'd1, 8'h00, pk(8'h01, 8'h00, 8'h00, 8'h00), pk(8'h01, 8'h00, 8'h00, 8'h00), 8'h01, 1'b0};
    vecs[8]  = '{8'd0, 8'h80, pk(8'h00, 8'h00, 8'h00, 8'h00), pk(8'h00, 8'h00, 8'h00, 8'h00), 8'h80, 1'b1};
    vecs[9]  = '{8'd2, 8'h00, pk(8'h40, 8'h40, 8'h00, 8'h00), pk(8'h20, 8'h20, 8'h00, 8'h00), 8'h40, 1'b0};
    vecs[10] = '{8'd1, 8'h68, pk(8'hC0, 8'h00, 8'h00, 8'h00), pk(8'h40, 8'h00, 8'h00, 8'h00), 8'h60, 1'b0};
    vecs[11] = '{8'd1, 8'h00, pk(8'hC0, 8'h00, 8'h00, 8'h00), pk(8'h60, 8'h00, 8'h00, 8'h00), 8'hA0, 1'b0};
    vecs[12] = '{8'd1, 8'h40, pk(8'h41, 8'h00, 8'h00, 8'h00), pk(8'h41, 8'h00, 8'h00, 8'h00), 8'h61, 1'b0};
    vecs[13] = '{8'd4, 8'h20, pk(8'h40, 8'h60, 8'hC0, 8'h20), pk(8'h20, 8'h20, 8'h40, 8'h20), 8'h48, 1'b0};

    bus.cmd_valid    = 1'b0;
    bus.cmd_len      = 8'd0;
    bus.cmd_acc_init = 8'h00;
    bus.op_valid     = 1'b0;
    bus.op_a         = 8'h00;
    bus.op_b         = 8'h00;
    bus.res_ready    = 1'b0;
    rst              = 1'b1;
    tick;
    tick;
    rst = 1'b0;

    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_op_ready", 32'(bus.op_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_nar", 32'(bus.res_nar), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ops_done", 32'(bus.ops_done), 32'd0);

    // Operands offered while idle must not be consumed.
    bus.op_valid = 1'b1;
    bus.op_a     = 8'h40;
    bus.op_b     = 8'h40;
    tick;
    tick;
    check("idle_op_ready", 32'(bus.op_ready), 32'd0);
    check("idle_ops_done", 32'(bus.ops_done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    bus.op_valid = 1'b0;

    for (int v = 0; v < 14; v++)
      run_cmd($sformatf("vec%0d", v), vecs[v].len, vecs[v].init, vecs[v].a, vecs[v].b,
              0, 0, vecs[v].exp_d, vecs[v].exp_n);

    // Flow control: 2-cycle operand gaps, result back-pressured for 5 cycles.
    run_cmd("flow", vecs[0].len, vecs[0].init, vecs[0].a, vecs[0].b, 2, 5,
            vecs[0].exp_d, vecs[0].exp_n);

    // Reset mid-command after 2 of 4 pairs.
    bus.cmd_valid    = 1'b1;
    bus.cmd_len      = 8'd4;
    bus.cmd_acc_init = 8'h00;
    tick;
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b1;
    bus.op_a      = 8'h40;
    bus.op_b      = 8'h40;
    tick;
    tick;
    bus.op_valid = 1'b0;
    check("mid_ops_done", 32'(bus.ops_done), 32'd2);
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_ops_done", 32'(bus.ops_done), 32'd0);
    check("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("mrst_op_ready", 32'(bus.op_ready), 32'd0);
    tick;
    check("mrst_no_result", 32'(bus.res_valid), 32'd0);
    run_cmd("after_rst", 8'd1, 8'h00, pk(8'h60, 8'h00, 8'h00, 8'h00),
            pk(8'h60, 8'h00, 8'h00, 8'h00), 0, 0, 8'h70, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/posit_dot_sched.md
Name: posit_dot_sched

Overview:
- Sequencer for one shared posit8 multiply-accumulate datapath: accepts a dot-product command (length, initial accumulator), then streams operand pairs through `posit_mac_8bit` at up to one pair per cycle.
- Returns the final posit result through a valid/ready channel.
- Owns the accumulator register and a sticky NaR flag.
- Sits between a host/DMA command source and the MAC, replacing free-running `ena`-gated accumulation with explicit framing.

Parameters:
- LEN_W, 8, width of command length and progress counter; max vector length is 2^LEN_W-1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_len  in  LEN_W  number of operand pairs
- cmd_acc_init  in  8  initial accumulator, posit8 es=0
- op_valid  in  1  operand pair offered
- op_ready  out  1  pair consumed when high with op_valid
- op_a  in  8  posit multiplicand
- op_b  in  8  posit multiplier
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  8  final accumulated posit
- res_nar  out  1  NaR (0x80) seen during the command
- busy  out  1  high in RUN or DONE
- ops_done  out  LEN_W  pairs consumed in the current command

Behaviour:
- Instantiates one `posit_mac_8bit` with in_a=op_a, in_b=op_b, in_c=acc. It is purely combinational; the MAC result is mac_out.
- States: IDLE, RUN, DONE. The state register plus acc, remaining, ops_done, res_data, res_valid, res_nar and the nar flag are all registered.
- Reset (rst=1 at a clock edge, any state, including mid-command):
  - state=IDLE.
  - acc=0x00, remaining=0, ops_done=0.
  - res_valid=0, res_data=0x00, res_nar=0, busy=0.
  - Any in-flight command is abandoned; no partial result is emitted.
- Decoded outputs: cmd_ready=(state==IDLE); op_ready=(state==RUN); busy=(state!=IDLE).
- IDLE, on cmd_valid&cmd_ready:
  - acc<=cmd_acc_init; ops_done<=0; nar<=(cmd_acc_init==0x80).
  - If cmd_len==0: res_data<=cmd_acc_init, res_nar<=(cmd_acc_init==0x80), res_valid<=1, go to DONE. The result is visible the cycle after the command.
  - Otherwise: remaining<=cmd_len, go to RUN.
  - op_valid is ignored in IDLE and DONE; no operand is consumed.
- RUN, on op_valid&op_ready (one pair per cycle max; bubbles allowed):
  - acc_next = (nar | mac_out==0x80) ? 0x80 : mac_out. NaR is sticky and overrides any later zero bypass.
  - acc<=acc_next; nar<=nar|(mac_out==0x80); ops_done<=ops_done+1; remaining<=remaining-1.
  - If remaining==1: res_data<=acc_next, res_nar<=nar|(mac_out==0x80), res_valid<=1, go to DONE.
  - Latency: the result is registered one cycle after the final operand handshake.
  - No handshake: all state holds.
- DONE:
  - res_valid, res_data and res_nar hold stable until res_ready=1.
  - On res_valid&res_ready: res_valid<=0, go to IDLE. cmd_ready rises the following cycle; there is no same-cycle result/command overlap.
  - res_data and res_nar keep their last value after the handshake until the next result is loaded.
- Width rules:
  - ops_done never exceeds cmd_len; no wrap is possible within a command.
  - remaining is LEN_W bits and never decrements below 1 in RUN.
- Arithmetic is exactly the `posit_mac_8bit` result: rounding, zero bypass, NaR=0x80. The block adds no rounding of its own.

Test Plan:
- Basic dot product: cmd_len=3, init 0x00; pairs (0x40,0x40), (0x40,0x60), (0x20,0x60) back-to-back -> res_data=0x70 (4.0), res_nar=0, res_valid one cycle after the 3rd handshake, ops_done=3.
- Zero-length command: cmd_len=0, init 0x68 -> res_valid=1 next cycle, res_data=0x68; op_ready never asserted; res_nar=0.
- NaR stickiness: cmd_len=3, init 0x40; pairs (0x80,0x40), (0x00,0x40), (0x40,0x40) -> res_data=0x80, res_nar=1, even though pair 2 hits the zero bypass.
- Flow control: operand stream with op_valid gaps of 2 cycles, then res_ready held low for 5 cycles -> result identical to gap-free run; res_data stable while res_valid=1&res_ready=0; cmd_ready=0 throughout; IDLE one cycle after res_ready=1.
- Reset mid-command: cmd_len=4, assert rst after 2 pairs -> next cycle res_valid=0, busy=0, ops_done=0, cmd_ready=1. A new cmd_len=1, init 0x00, pair (0x60,0x60) -> res_data=0x70 (4.0).
